// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide scheduler for the EX stage.
//
// Runs one shared iterative engine. Restoring shift-subtract is used for
// div/divu, and shift-add for mult/multu when MDU_ITER_MUL_EN is defined.
// The pipeline is held through stallreq_for_ex while an operation is in
// flight. The result then leaves in a single HI/LO write beat.
//
// Build option:
//   MDU_ITER_MUL_EN  defined   -> mult/multu run on the iterative engine
//                    undefined -> mult/multu complete combinationally in IDLE
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector; stall[3]=1 holds EX
//   cancel            flush: abort and return to IDLE without a write
//   op_div/op_divu/op_mult/op_multu  one-hot request from EX
//   src_a, src_b      rs (dividend/multiplicand), rt (divisor/multiplier)
//   stallreq_for_ex   stall request while a result is pending
//   hi_we, lo_we      HI/LO write strobes
//   hi_o, lo_o        HI/LO write data
//   busy              state != IDLE
//
// state | meaning
// IDLE  | waiting for a request; combinational multiply in the default build
// RUN   | one engine iteration per cycle, WIDTH iterations in total
// DIVZ  | divide by zero; the fixed result is already loaded
// DONE  | result valid; write when EX is not held
module mdu_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             cancel,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stallreq_for_ex,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DIVZ, DONE} state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state, state_n;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] acc, q, d;
  logic             neg_q, neg_r;
  logic             req_div, req_mul, req_iter, signed_req, accept, divz_req;
  logic             sign_a, sign_b, we;
  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_acc_n, div_q_n;
  logic             unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  assign req_div    = op_div | op_divu;
  assign req_mul    = op_mult | op_multu;
  assign signed_req = op_div | op_mult;
`ifdef MDU_ITER_MUL_EN
  assign req_iter   = req_div | req_mul;
`else
  assign req_iter   = req_div;
`endif
  assign accept     = (state == IDLE) && req_iter && !cancel;
  assign divz_req   = req_div && (src_b == '0);

  assign sign_a = signed_req & src_a[WIDTH-1];
  assign sign_b = signed_req & src_b[WIDTH-1];
  assign mag_a  = sign_a ? -src_a : src_a;
  assign mag_b  = sign_b ? -src_b : src_b;

  // Restoring division step. The partial remainder stays below the divisor,
  // so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    div_shift = {acc, q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d};
    if (!div_diff[WIDTH]) begin
      div_acc_n = div_diff[WIDTH-1:0];
      div_q_n   = {q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_n = div_shift[WIDTH-1:0];
      div_q_n   = {q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MDU_ITER_MUL_EN
  logic             is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_i;

  // Shift-add step. After WIDTH steps {acc,q} holds the full product.
  assign mul_sum = q[0] ? ({1'b0, acc} + {1'b0, d}) : {1'b0, acc};
  assign prod_i  = neg_q ? -{acc, q} : {acc, q};
`else
  logic [2*WIDTH-1:0] prod_raw, prod_c;

  assign prod_raw = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign prod_c   = (sign_a ^ sign_b) ? -prod_raw : prod_raw;
`endif

  always_comb begin
    res_hi = neg_r ? -acc : acc;
    res_lo = neg_q ? -q : q;
`ifdef MDU_ITER_MUL_EN
    if (is_mul) begin
      res_hi = prod_i[2*WIDTH-1:WIDTH];
      res_lo = prod_i[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    hi_o = res_hi;
    lo_o = res_lo;
`ifndef MDU_ITER_MUL_EN
    if (state == IDLE && req_mul && !cancel) begin
      hi_o = prod_c[2*WIDTH-1:WIDTH];
      lo_o = prod_c[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    state_n         = state;
    stallreq_for_ex = 1'b0;
    we              = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stallreq_for_ex = 1'b1;
          state_n         = divz_req ? DIVZ : RUN;
        end
`ifndef MDU_ITER_MUL_EN
        else if (req_mul && !cancel) begin
          we = 1'b1;
        end
`endif
      end
      RUN: begin
        stallreq_for_ex = 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      DIVZ: begin
        stallreq_for_ex = 1'b1;
        state_n         = DONE;
      end
      DONE: begin
        if (!stall[3]) begin
          we      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (cancel) begin
      state_n = IDLE;
      we      = 1'b0;
    end
  end

  assign hi_we = we;
  assign lo_we = we;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`ifdef MDU_ITER_MUL_EN
      is_mul <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= '0;
`ifdef MDU_ITER_MUL_EN
        is_mul <= req_mul;
`endif
        if (divz_req) begin
          // Quotient all-ones and remainder equal to the raw dividend.
          acc   <= src_a;
          q     <= '1;
          d     <= src_b;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (req_div) begin
          acc   <= '0;
          q     <= mag_a;
          d     <= mag_b;
          neg_q <= sign_a ^ sign_b;
          neg_r <= sign_a;
        end else begin
          acc   <= '0;
          q     <= mag_b;
          d     <= mag_a;
          neg_q <= sign_a ^ sign_b;
          neg_r <= 1'b0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
`ifdef MDU_ITER_MUL_EN
        if (is_mul) begin
          acc <= mul_sum[WIDTH:1];
          q   <= {mul_sum[0], q[WIDTH-1:1]};
        end else begin
          acc <= div_acc_n;
          q   <= div_q_n;
        end
`else
        acc <= div_acc_n;
        q   <= div_q_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        cancel;
  logic        op_div, op_divu, op_mult, op_multu;
  logic [31:0] src_a, src_b;
  logic        stallreq_for_ex, hi_we, lo_we, busy;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  localparam logic [3:0] DIV   = 4'b1000;
  localparam logic [3:0] DIVU  = 4'b0100;
  localparam logic [3:0] MULT  = 4'b0010;
  localparam logic [3:0] MULTU = 4'b0001;
`ifdef MDU_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 0;
`endif

  always #5 clk = ~clk;

  mdu_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .cancel(cancel),
    .op_div(op_div), .op_divu(op_divu), .op_mult(op_mult), .op_multu(op_multu),
    .src_a(src_a), .src_b(src_b),
    .stallreq_for_ex(stallreq_for_ex), .hi_we(hi_we), .lo_we(lo_we),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request and follows it to its strobe. lat = cycles from the
  // request cycle to the strobe; hold = cycles of stall[3] starting at lat.
  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat, input int hold);
    int cyc;
    bit seen;
    logic [63:0] got;
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    {op_div, op_divu, op_mult, op_multu} = op;
    src_a = a;
    src_b = b;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc <= lat + hold + 4) begin
      stall = (cyc >= lat && cyc < lat + hold) ? 6'b001000 : 6'b000000;
      #1;
      check({tag, "_stallreq"}, 64'(stallreq_for_ex), 64'(lat > 0 && cyc < lat));
      check({tag, "_busy"}, 64'(busy), 64'(lat > 0 && cyc >= 1));
      if (hold > 0 && cyc >= lat)
        check({tag, "_held_lo"}, 64'(lo_o), 64'(elo));
      if (hi_we || lo_we) begin
        seen = 1;
        check({tag, "_we_pair"}, 64'({hi_we, lo_we}), 64'b11);
        check({tag, "_strobe_cycle"}, 64'(cyc), 64'(lat + hold));
        check({tag, "_sb_size"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check({tag, "_hilo"}, {hi_o, lo_o}, got);
        end
        {op_div, op_divu, op_mult, op_multu} = 4'b0000;
      end
      @(negedge clk);
      cyc++;
    end
    stall = 6'b0;
    {op_div, op_divu, op_mult, op_multu} = 4'b0000;
    check({tag, "_strobe_seen"}, 64'(seen), 64'd1);
    if (!seen) begin
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    #1;
    check({tag, "_post_idle"}, 64'({busy, hi_we}), 64'b00);
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; cancel = 1'b0;
    {op_div, op_divu, op_mult, op_multu} = 4'b0000;
    src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 64'({stallreq_for_ex, hi_we, lo_we, busy}), 64'b0000);
    check("reset_data", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    do_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 0);
    do_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 0);
    do_op("divu_5_0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 0);
    do_op("div_min_0", DIV, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0);
    do_op("divu_9_3_hold", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, 3);
    do_op("multu_max_2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MUL_LAT, 0);
    do_op("mult_m3_5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, 0);
    do_op("divu_max_max", DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 33, 0);

    // Cancel ten cycles into a divide: no write ever, stall drops next cycle.
    @(negedge clk);
    {op_div, op_divu, op_mult, op_multu} = DIV;
    src_a = 32'd100;
    src_b = 32'd3;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      cancel = (cyc == 10);
      if (cyc == 11) {op_div, op_divu, op_mult, op_multu} = 4'b0000;
      #1;
      if (cyc <= 10) check("cancel_stallreq_pre", 64'(stallreq_for_ex), 64'd1);
      if (cyc == 11 || cyc == 12)
        check("cancel_after", 64'({stallreq_for_ex, busy}), 64'b00);
      check("cancel_no_we", 64'({hi_we, lo_we}), 64'b00);
      @(negedge clk);
    end
    cancel = 1'b0;

    do_op("divu_after_cancel", DIVU, 32'd50, 32'd6, 32'd2, 32'd8, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multi-cycle multiply/divide scheduler for the EX stage. Accepts `div`/`divu`/`mult`/`multu` from the EX-stage decode and sequences one shared iterative shift-subtract/shift-add engine. Freezes the pipeline through the stall controller while the engine runs, then delivers a single HI/LO write beat. Sits beside the ALU in EX; its HI/LO outputs merge into the EX-to-MEM HI/LO write fields.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `stall` in `StallBus` — pipeline stall vector; bit 3 (EX) `Stop` means EX is held by a later stage.
- `cancel` in 1 — abort current operation (exception/flush); no HI/LO write.
- `op_div`, `op_divu`, `op_mult`, `op_multu` in 1 each — one-hot operation request from EX; all 0 = no request.
- `src_a` in `WIDTH` — rs value (dividend / multiplicand).
- `src_b` in `WIDTH` — rt value (divisor / multiplier).
- `stallreq_for_ex` out 1 — to stall controller; high while a result is pending.
- `hi_we`, `lo_we` out 1 each — HI/LO write strobes.
- `hi_o`, `lo_o` out `WIDTH` each — HI/LO write data.
- `busy` out 1 — state ≠ IDLE.

## Operation
- States: IDLE, RUN, DIVZ, DONE.
- IDLE + div/divu (or mult/multu with macro) + !cancel:
  - latch operand magnitudes and sign info; clear the 6-bit counter.
  - if a div/divu request has `src_b==0`, go to DIVZ; otherwise go to RUN.
- RUN: one iteration per cycle; counter increments. After iteration `WIDTH`-1, go to DONE.
- DIVZ: go to DONE next cycle with quotient=all-ones and remainder=dividend (signed: raw `src_a`).
- DONE:
  - if `stall[3]==NoStop`: assert `hi_we`=`lo_we`=1 for this cycle and go to IDLE.
  - otherwise hold DONE with results unchanged.
- Division semantics:
  - divide magnitudes.
  - signed: negate the quotient if operand signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0 (wraps; no trap).
  - HI=remainder, LO=quotient.
- Multiplication: full 2·`WIDTH` product; HI=upper half, LO=lower half. Signed uses magnitudes, then the product is negated if operand signs differ.
- `cancel` in any state: next state IDLE, no HI/LO write. `cancel` beats an accept in the same cycle.
- Requests arriving while not IDLE are ignored; the request held in EX is the one being serviced.

## Timing
- Reset: state IDLE, counter 0, `stallreq_for_ex`=0, `hi_we`=`lo_we`=0, `hi_o`=`lo_o`=0, `busy`=0.
- `stallreq_for_ex` is combinational:
  - high in the accept cycle (IDLE with a request), and in RUN and DIVZ.
  - low in DONE, so the pipeline advances at the end of the DONE cycle.
- Iterative latency: request first seen at cycle T; RUN covers T+1..T+`WIDTH`; DONE write strobe at T+`WIDTH`+1 (T+33 at default).
- Divide-by-zero latency: DIVZ at T+1, write strobe at T+2.
- `hi_o`/`lo_o` are stable from DONE entry until the strobe cycle, including while DONE is held.
- The accept-cycle stall plus the DONE→IDLE transition guarantee one execution per instruction: the next cycle's EX holds the following instruction.

## Configuration
- `MDU_ITER_MUL_EN` defined:
  - mult/multu use the iterative engine: RUN for `WIDTH` cycles, strobe at T+33, stall asserted as for divide.
- `MDU_ITER_MUL_EN` undefined:
  - mult/multu complete combinationally in the request cycle: `hi_we`=`lo_we`=1 with the product, `stallreq_for_ex`=0, state remains IDLE.
  - if `stall[3]==Stop` in that cycle, the strobe is still asserted. The downstream EX/MEM register does not capture it; it re-fires when the instruction is re-presented.

## Test plan
- Unsigned divide: divu 100/7 → strobe at T+33, `lo_o`=14, `hi_o`=2, `stallreq_for_ex` high T..T+32.
- Signed divide: div −7/2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. Also div 0x80000000/0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- Divide by zero: divu 5/0 → strobe at T+2, `lo_o`=0xFFFFFFFF, `hi_o`=5.
- Held completion: divu 9/3 with `stall[3]`=Stop at T+33..T+35 → no strobe during the hold; `lo_o`=3 stable; single strobe at T+36, then IDLE.
- Cancel: div started, `cancel` at T+10 → IDLE at T+11, no strobe ever, `stallreq_for_ex`=0 from T+11.
- Multiply: multu 0xFFFFFFFF × 2 → `hi_o`=1, `lo_o`=0xFFFFFFFE. Strobe at T with macro off; strobe at T+33 with `MDU_ITER_MUL_EN` defined.
